nibble_serial_adder: RTL and testbench

Sequencing controller that adds two W-bit operands (W = 4·NIB) through one shared `adder4` slice, one 4-bit nibble per clock, least-significant nibble first. It owns the operand shift registers, the inter-slice carry register and a start/busy/done handshake, so wide additions reuse the single 4-bit ripple adder instead of a W-bit one. It sits between a requesting master, such as a bench or an accumulator FSM, and the `adder4` instance it contains.

---
 rtl/nibble_serial_adder.sv | 118 +++++++++++
 tb/tb_nibble_serial_adder.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Sequencing controller that adds two W-bit operands through one shared 4-bit
// ripple slice, one nibble per clock, least-significant nibble first.

module adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] carry;

  always_comb begin
    carry    = '0;
    s        = '0;
    carry[0] = ci;
    for (int unsigned i = 0; i < 4; i++) begin
      s[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    co = carry[4];
  end
endmodule

module nibble_serial_adder #(
  parameter int NIB = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4*NIB-1:0] a,
  input  logic [4*NIB-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [4*NIB-1:0] sum,
  output logic             cout
);
  localparam int unsigned W  = 4 * NIB;
  localparam int unsigned KW = $clog2(NIB) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [W-1:0]  ra;
  logic [W-1:0]  rb;
  logic [W-1:0]  racc;
  logic          c;
  logic [KW-1:0] k;

  logic [3:0]    slice_sum;
  logic          slice_co;
  logic [W-1:0]  acc_next;

  adder4 u_slice (
    .a  (ra[3:0]),
    .b  (rb[3:0]),
    .ci (c),
    .s  (slice_sum),
    .co (slice_co)
  );

  assign acc_next = {slice_sum, racc[W-1:4]};

  // The last slice loads sum/cout straight from the adder so the result lands
  // together with the done pulse, not one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ra    <= '0;
      rb    <= '0;
      racc  <= '0;
      c     <= 1'b0;
      k     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            ra    <= a;
            rb    <= b;
            c     <= cin;
            k     <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          racc <= acc_next;
          c    <= slice_co;
          ra   <= ra >> 4;
          rb   <= rb >> 4;
          k    <= k + KW'(1);
          if (k == KW'(NIB - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            sum   <= acc_next;
            cout  <= slice_co;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: the driver queues a+b+cin per
// accepted request, the monitor checks each done pulse and held results.

module tb_nibble_serial_adder;
  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int vectors = 0;
  int miscompares = 0;

  logic [W:0] sb[$];
  logic [W:0] held = '0;
  logic       armed = 1'b0;

  nibble_serial_adder #(.NIB(NIB)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
  endfunction

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // A reset edge abandons anything in flight and clears the visible result.
  always @(posedge clk) begin
    if (reset) begin
      sb.delete();
      held  = '0;
      armed = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (armed && !reset) begin
      if (busy && done) check("busy_done_exclusive", 1, 0);
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          held = sb.pop_front();
          check("result", {cout, sum}, held);
        end
      end else begin
        check("held_result", {cout, sum}, held);
      end
    end
  end

  // Drive one request; returns at the negedge of cycle 1 with start still high.
  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    @(negedge clk);
    a = x; b = y; cin = ci; start = 1'b1;
    sb.push_back(ref_add(x, y, ci));
    @(negedge clk);
  endtask

  // Waits (bounded) for done; optionally pulses an ignored start in RUN cycle 2.
  task automatic wait_run(input bit inject, input bit hold);
    int lat = 1;
    int bcnt = 0;
    while (!done && lat < 4 * NIB + 10) begin
      if (inject && lat == 2) begin
        a = 16'h1111; b = 16'h1111; cin = 1'b0; start = 1'b1;
      end else if (!hold) begin
        start = 1'b0;
      end
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    check("latency", (W+1)'(lat), (W+1)'(NIB + 1));
    check("busy_cycles", (W+1)'(bcnt), (W+1)'(NIB));
  endtask

  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                    input bit inject);
    launch(x, y, ci);
    start = 1'b0;
    wait_run(inject, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", {busy, done, cout, sum[W-2:0]}, '0);
    reset = 1'b0;

    op(16'h1234, 16'h4321, 1'b0, 1'b0);
    op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);

    op(16'h0F0F, 16'h00F1, 1'b0, 1'b1);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_after_ignore", {busy, done}, '0);

    launch(16'hABCD, 16'h1357, 1'b1);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_mid_run", {busy, done, cout, sum[W-2:0]}, '0);
    check("reset_sum", {1'b0, sum}, '0);
    op(16'h0001, 16'h0001, 1'b0, 1'b0);

    launch(16'h8000, 16'h8000, 1'b0);
    wait_run(1'b0, 1'b1);
    a = 16'h0003; b = 16'h0004; cin = 1'b0;
    sb.push_back(ref_add(16'h0003, 16'h0004, 1'b0));
    @(negedge clk);
    start = 1'b0;
    wait_run(1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      op(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", (W+1)'(sb.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
